// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
//   INSTR_W / ADDR_W : instruction and address widths
//   PC_STEP          : byte distance between sequential fetches
//   fetch_state_e    : fetch FSM states (IDLE, REQ, KILL)
//   fetch_entry_t    : prefetch queue payload {instr, pc}
//   align_pc()       : clears the byte-offset bits of an address
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Word-align a fetch target.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: synchronous FIFO of fetch entries with flush.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             drop all entries at the edge (wins over enq/deq)
//   enq, enq_data     push one entry
//   deq               pop the head (ignored when empty)
//   head_valid, head  current head entry
//   count             number of valid entries
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq,
  input  fetch_entry_t     enq_data,
  input  logic             deq,
  output logic             head_valid,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     storage [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             deq_ok;

  assign deq_ok = deq && (cnt != '0);

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq)    wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq_ok})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage needs no reset; validity comes from cnt.
  always_ff @(posedge clk) begin
    if (enq && !flush) storage[wr_ptr] <= enq_data;
  end

  assign head_valid = (cnt != '0);
  assign head       = storage[rd_ptr];
  assign count      = cnt;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues single-outstanding word
// requests to instruction memory and buffers responses in a prefetch queue
// feeding the decode stage. Redirects flush the queue and kill in-flight
// responses.
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   imem_req_o, imem_addr_o          memory request (held until response)
//   imem_rvalid_i, imem_rdata_i      memory response
//   instr_valid_o, instr_ready_i     decode handshake
//   instr_o, pc_o, pc_plus4_o        head instruction, its address, address+4
//   redirect_i, redirect_pc_i        branch/jump redirect
//   fetch_cnt_o, kill_cnt_o          enqueue / discard counters
// Build option: define FETCH_PERF_CNT_EN to implement the counters; otherwise
// both counter outputs are tied to zero.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [ADDR_W-1:0]  pc_plus4_o,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic [31:0]        fetch_cnt_o,
  output logic [31:0]        kill_cnt_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              req_q;
  logic              enq, deq, flush, kill;
  logic [CNT_W-1:0]  q_count;
  logic [CNT_W-1:0]  cnt_after_enq;
  logic              head_valid;
  fetch_entry_t      head;
  fetch_entry_t      enq_entry;

  assign enq_entry     = '{instr: imem_rdata_i, pc: fetch_pc_q};
  // A redirect cancels any dequeue in the same cycle.
  assign deq           = head_valid && instr_ready_i && !redirect_i;
  // Occupancy after a response is enqueued; REQ is only entered below DEPTH,
  // so this never overflows CNT_W.
  assign cnt_after_enq = q_count + CNT_W'(1) - CNT_W'(deq);

  // State, PC and request flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= (state_d == REQ);
    end
  end

  // Next-state, PC update and queue control.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    enq        = 1'b0;
    kill       = 1'b0;
    flush      = 1'b0;

    if (redirect_i) begin
      flush      = 1'b1;
      fetch_pc_d = align_pc(redirect_pc_i);
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imem_rvalid_i) begin
            kill    = 1'b1;
            state_d = REQ;
          end else begin
            state_d = KILL;
          end
        end
        KILL: begin
          // Stale response may land together with a new redirect.
          if (imem_rvalid_i) begin
            kill    = 1'b1;
            state_d = REQ;
          end else begin
            state_d = KILL;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (q_count < CNT_W'(DEPTH)) state_d = REQ;
        end
        REQ: begin
          if (imem_rvalid_i) begin
            enq        = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_STEP;
            state_d    = (cnt_after_enq < CNT_W'(DEPTH)) ? REQ : IDLE;
          end
        end
        KILL: begin
          if (imem_rvalid_i) begin
            kill    = 1'b1;
            state_d = (q_count < CNT_W'(DEPTH)) ? REQ : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk        (clk_i),
    .rst        (rst_i),
    .flush      (flush),
    .enq        (enq),
    .enq_data   (enq_entry),
    .deq        (deq),
    .head_valid (head_valid),
    .head       (head),
    .count      (q_count)
  );

  assign imem_req_o    = req_q;
  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = head_valid;
  assign instr_o       = head.instr;
  assign pc_o          = head.pc;
  assign pc_plus4_o    = head.pc + PC_STEP;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] kill_cnt_q;

  // Free-running event counters, wrap at 2^32.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      if (enq)  fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (kill) kill_cnt_q  <= kill_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign kill_cnt_o  = kill_cnt_q;
`else
  logic unused_kill;
  assign unused_kill = kill;
  assign fetch_cnt_o = '0;
  assign kill_cnt_o  = '0;
`endif

endmodule
